// File: rtl/cache.sv
// Two-way set-associative, write-back/write-allocate cache: 16 sets of 128-byte lines,
// line data held in four external 1024x8 SRAM byte lanes; tags/valid/dirty/LRU in flops.
module cache (
    input  logic        clk,
    input  logic        rst,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [4:0]  loadcntrl,
    input  logic [2:0]  storecntrl,
    output logic [31:0] dout,
    output logic        cache_rdy,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic [9:0]  cell_0_addr,
    output logic [7:0]  cell_0_din,
    output logic        cell_0_sense_en,
    output logic        cell_0_wen,
    input  logic [7:0]  cell_0_dout,
    output logic [9:0]  cell_1_addr,
    output logic [7:0]  cell_1_din,
    output logic        cell_1_sense_en,
    output logic        cell_1_wen,
    input  logic [7:0]  cell_1_dout,
    output logic [9:0]  cell_2_addr,
    output logic [7:0]  cell_2_din,
    output logic        cell_2_sense_en,
    output logic        cell_2_wen,
    input  logic [7:0]  cell_2_dout,
    output logic [9:0]  cell_3_addr,
    output logic [7:0]  cell_3_din,
    output logic        cell_3_sense_en,
    output logic        cell_3_wen,
    input  logic [7:0]  cell_3_dout
);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, SRAM_TO_BUF, BUF_TO_MEM, MEM_TO_BUF, BUF_TO_SRAM, ACCESS, DONE
    } state_t;

    state_t      state, state_next;
    logic [31:0] req_addr, req_din;
    logic [4:0]  req_load;
    logic [2:0]  req_store;
    logic        req_write;
    logic        way;
    logic [4:0]  cnt;
    logic        rd_pending, rd_from_mem;
    logic [4:0]  rd_idx;
    logic [31:0] dout_q;

    logic [20:0]      tags [2][16];
    logic [1:0][15:0] valid, dirty;
    logic [15:0]      lru;
    logic [31:0]      line_buf [32];

    logic [20:0] req_tag;
    logic [3:0]  req_set;
    logic [4:0]  req_word;
    logic        hit0, hit1, victim, last;
    logic [31:0] lane_dout, load_value;
    logic [9:0]  sram_addr;
    logic [31:0] sram_data;
    logic        sram_sense;
    logic [3:0]  sram_wen;

    assign req_tag   = req_addr[31:11];
    assign req_set   = req_addr[10:7];
    assign req_word  = req_addr[6:2];
    assign hit0      = valid[0][req_set] && (tags[0][req_set] == req_tag);
    assign hit1      = valid[1][req_set] && (tags[1][req_set] == req_tag);
    assign victim    = !valid[0][req_set] ? 1'b0 : (!valid[1][req_set] ? 1'b1 : lru[req_set]);
    assign last      = (cnt == 5'd31);
    assign lane_dout = {cell_3_dout, cell_2_dout, cell_1_dout, cell_0_dout};

    function automatic logic [3:0] store_mask(input logic [2:0] sc, input logic [1:0] a);
        if (sc[0])      return 4'b0001 << a;
        else if (sc[1]) return a[1] ? 4'b1100 : 4'b0011;
        else if (sc[2]) return 4'b1111;
        else            return 4'b0000;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] sc, input logic [31:0] d);
        if (sc[0])      return {4{d[7:0]}};
        else if (sc[1]) return {2{d[15:0]}};
        else            return d;
    endfunction

    function automatic logic [31:0] load_format(input logic [4:0] lc, input logic [1:0] a,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        if (lc[0])                       return {{24{b[7]}}, b};
        else if (lc[1])                  return {{16{h[15]}}, h};
        else if (lc[2] || lc == 5'd0)    return w;
        else if (lc[3])                  return {24'd0, b};
        else if (lc[4])                  return {16'd0, h};
        else                             return w;
    endfunction

    assign load_value = load_format(req_load, req_addr[1:0], lane_dout);

    // NOTE: every output and next-state signal gets a default before the case, so no path leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        cache_rdy  = 1'b0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        mem_addr   = 32'd0;
        mem_din    = 32'd0;
        sram_addr  = 10'd0;
        sram_data  = 32'd0;
        sram_sense = 1'b0;
        sram_wen   = 4'b0000;
        dout       = dout_q;
        case (state)
            IDLE: begin
                cache_rdy = 1'b1;
                if (wen || ren) state_next = LOOKUP;
            end
            LOOKUP: begin
                if (hit0 || hit1)                                  state_next = ACCESS;
                else if (valid[victim][req_set] && dirty[victim][req_set]) state_next = SRAM_TO_BUF;
                else                                               state_next = MEM_TO_BUF;
            end
            SRAM_TO_BUF: begin
                sram_addr  = {way, req_set, cnt};
                sram_sense = 1'b1;
                if (last) state_next = BUF_TO_MEM;
            end
            BUF_TO_MEM: begin
                mem_wen  = 1'b1;
                mem_addr = {tags[way][req_set], req_set, cnt, 2'b00};
                mem_din  = line_buf[cnt];
                if (last) state_next = MEM_TO_BUF;
            end
            MEM_TO_BUF: begin
                mem_ren  = 1'b1;
                mem_addr = {req_tag, req_set, cnt, 2'b00};
                if (last) state_next = BUF_TO_SRAM;
            end
            BUF_TO_SRAM: begin
                sram_addr = {way, req_set, cnt};
                sram_data = line_buf[cnt];
                sram_wen  = 4'b1111;
                if (last) state_next = ACCESS;
            end
            ACCESS: begin
                sram_addr = {way, req_set, req_word};
                if (req_write) begin
                    sram_data = store_data(req_store, req_din);
                    sram_wen  = store_mask(req_store, req_addr[1:0]);
                end else begin
                    sram_sense = 1'b1;
                end
                state_next = DONE;
            end
            DONE: begin
                if (!req_write) dout = load_value;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Reset silences every strobe at once so an aborted miss writes nothing further.
        if (rst) begin
            cache_rdy  = 1'b0;
            mem_ren    = 1'b0;
            mem_wen    = 1'b0;
            mem_addr   = 32'd0;
            mem_din    = 32'd0;
            sram_addr  = 10'd0;
            sram_data  = 32'd0;
            sram_sense = 1'b0;
            sram_wen   = 4'b0000;
            dout       = 32'd0;
        end
    end

    assign cell_0_addr = sram_addr;  assign cell_0_din = sram_data[7:0];
    assign cell_1_addr = sram_addr;  assign cell_1_din = sram_data[15:8];
    assign cell_2_addr = sram_addr;  assign cell_2_din = sram_data[23:16];
    assign cell_3_addr = sram_addr;  assign cell_3_din = sram_data[31:24];
    assign cell_0_sense_en = sram_sense;  assign cell_0_wen = sram_wen[0];
    assign cell_1_sense_en = sram_sense;  assign cell_1_wen = sram_wen[1];
    assign cell_2_sense_en = sram_sense;  assign cell_2_wen = sram_wen[2];
    assign cell_3_sense_en = sram_sense;  assign cell_3_wen = sram_wen[3];

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            valid       <= '0;
            dirty       <= '0;
            lru         <= '0;
            dout_q      <= 32'd0;
            cnt         <= 5'd0;
            way         <= 1'b0;
            rd_pending  <= 1'b0;
            rd_from_mem <= 1'b0;
            rd_idx      <= 5'd0;
            req_addr    <= 32'd0;
            req_din     <= 32'd0;
            req_load    <= 5'd0;
            req_store   <= 3'd0;
            req_write   <= 1'b0;
        end else begin
            state       <= state_next;
            rd_pending  <= (state == SRAM_TO_BUF) || (state == MEM_TO_BUF);
            rd_from_mem <= (state == MEM_TO_BUF);
            rd_idx      <= cnt;
            cnt <= (state inside {SRAM_TO_BUF, BUF_TO_MEM, MEM_TO_BUF, BUF_TO_SRAM}) ? cnt + 5'd1 : 5'd0;
            case (state)
                IDLE: if (wen || ren) begin
                    req_addr  <= addr;
                    req_din   <= din;
                    req_load  <= loadcntrl;
                    req_store <= storecntrl;
                    req_write <= wen;
                end
                LOOKUP: way <= hit1 ? 1'b1 : (hit0 ? 1'b0 : victim);
                BUF_TO_SRAM: if (last) begin
                    valid[way][req_set] <= 1'b1;
                    dirty[way][req_set] <= 1'b0;
                end
                ACCESS: begin
                    lru[req_set] <= ~way;
                    if (req_write) dirty[way][req_set] <= 1'b1;
                end
                DONE: if (!req_write) dout_q <= load_value;
                default: ;
            endcase
        end
    end

    // NOTE: line buffer and tag arrays are plain storage with no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (rd_pending) line_buf[rd_idx] <= rd_from_mem ? mem_dout : lane_dout;
        if (!rst && state == BUF_TO_SRAM && last) tags[way][req_set] <= req_tag;
    end

endmodule

// File: tb/tb_cache.sv
// Bench for cache: external memory and SRAM lane models, directed scenarios, then random
// loads/stores checked against an architectural memory plus an LRU residency model.
module tb_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ren = 1'b0, wen = 1'b0;
    logic [31:0] addr = 32'd0, din = 32'd0;
    logic [4:0]  loadcntrl = 5'd0;
    logic [2:0]  storecntrl = 3'd0;
    logic [31:0] dout, mem_addr, mem_din;
    logic [31:0] mem_dout = 32'd0;
    logic        cache_rdy, mem_ren, mem_wen;
    logic [9:0]  c_addr [4];
    logic [7:0]  c_din [4];
    logic        c_sense [4];
    logic        c_wen [4];
    logic [7:0]  c_dout [4];

    int vectors = 0;
    int miscompares = 0;

    cache dut (
        .clk(clk), .rst(rst), .ren(ren), .wen(wen), .addr(addr), .din(din),
        .loadcntrl(loadcntrl), .storecntrl(storecntrl), .dout(dout), .cache_rdy(cache_rdy),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout),
        .cell_0_addr(c_addr[0]), .cell_0_din(c_din[0]), .cell_0_sense_en(c_sense[0]),
        .cell_0_wen(c_wen[0]), .cell_0_dout(c_dout[0]),
        .cell_1_addr(c_addr[1]), .cell_1_din(c_din[1]), .cell_1_sense_en(c_sense[1]),
        .cell_1_wen(c_wen[1]), .cell_1_dout(c_dout[1]),
        .cell_2_addr(c_addr[2]), .cell_2_din(c_din[2]), .cell_2_sense_en(c_sense[2]),
        .cell_2_wen(c_wen[2]), .cell_2_dout(c_dout[2]),
        .cell_3_addr(c_addr[3]), .cell_3_din(c_din[3]), .cell_3_sense_en(c_sense[3]),
        .cell_3_wen(c_wen[3]), .cell_3_dout(c_dout[3])
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, limit 100000 cycles");
        $fatal(1);
    end

    // Backing memory: untouched words read as a fixed function of their address.
    logic [31:0] bmem [bit [29:0]];
    int          n_rd = 0, n_wr = 0;
    logic [31:0] rd_first = 32'd0, rd_last = 32'd0, wr_first = 32'd0;
    logic        ren_d = 1'b0, wen_d = 1'b0;

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        return {wa, 2'b00} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [31:0] bmem_rd(input logic [29:0] wa);
        return bmem.exists(wa) ? bmem[wa] : init_word(wa);
    endfunction

    always @(posedge clk) begin
        if (mem_ren) begin
            mem_dout <= bmem_rd(mem_addr[31:2]);
            if (!ren_d) rd_first = mem_addr;
            rd_last = mem_addr;
            n_rd++;
        end
        if (mem_wen) begin
            bmem[mem_addr[31:2]] = mem_din;
            if (!wen_d) wr_first = mem_addr;
            n_wr++;
        end
        ren_d = mem_ren;
        wen_d = mem_wen;
    end

    logic [7:0] sram [4][1024];
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (c_sense[k]) c_dout[k] <= sram[k][c_addr[k]];
            if (c_wen[k])   sram[k][c_addr[k]] <= c_din[k];
        end
    end

    // Reference: architectural memory and, per set, up to two resident tags in MRU-first order.
    logic [31:0] ref_mem [bit [29:0]];
    logic [20:0] res_tag [16][2];
    int          res_n [16];
    bit          dirty_line [bit [24:0]];

    function automatic logic [31:0] ref_rd(input logic [29:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] ref_load(input logic [4:0] lc, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * a));
        h = 16'(w >> (16 * a[1]));
        case (lc)
            5'b00001: return 32'($signed(b));
            5'b00010: return 32'($signed(h));
            5'b01000: return {24'd0, b};
            5'b10000: return {16'd0, h};
            default:  return w;
        endcase
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 16; s++) res_n[s] = 0;
        dirty_line.delete();
        ref_mem.delete();
        foreach (bmem[k]) ref_mem[k] = bmem[k];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] lc, input logic [2:0] sc, input string tag);
        logic [20:0] t;
        logic [3:0]  s;
        logic [20:0] vtag;
        logic [31:0] w, exp_dout, old_dout;
        bit          hit, vdirty;
        int          exp_lat, lows, rd0, wr0;
        t = a[31:11];
        s = a[10:7];
        hit = 1'b0;
        vdirty = 1'b0;
        vtag = 21'd0;
        if (res_n[s] > 0 && res_tag[s][0] == t) hit = 1'b1;
        else if (res_n[s] > 1 && res_tag[s][1] == t) begin
            hit = 1'b1;
            res_tag[s][1] = res_tag[s][0];
            res_tag[s][0] = t;
        end
        if (!hit) begin
            if (res_n[s] == 2) begin
                vtag = res_tag[s][1];
                vdirty = dirty_line.exists({vtag, s});
                if (vdirty) dirty_line.delete({vtag, s});
            end else begin
                res_n[s]++;
            end
            res_tag[s][1] = res_tag[s][0];
            res_tag[s][0] = t;
        end
        exp_lat = hit ? 3 : (vdirty ? 131 : 67);
        old_dout = dout;
        if (wr) begin
            dirty_line[{t, s}] = 1'b1;
            w = ref_rd(a[31:2]);
            if (sc[0])      w[8 * a[1:0] +: 8] = d[7:0];
            else if (sc[1]) w[16 * a[1] +: 16] = d[15:0];
            else if (sc[2]) w = d;
            ref_mem[a[31:2]] = w;
            exp_dout = old_dout;
        end else begin
            exp_dout = ref_load(lc, a[1:0], ref_rd(a[31:2]));
        end

        check({tag, "_rdy_before"}, {31'd0, cache_rdy}, 32'd1);
        rd0 = n_rd;
        wr0 = n_wr;
        addr = a; din = d; loadcntrl = lc; storecntrl = sc;
        wen = wr; ren = !wr;
        @(negedge clk);
        lows = 0;
        while (cache_rdy !== 1'b1 && lows < 400) begin
            lows++;
            ren = 1'($urandom_range(0, 1));
            wen = 1'($urandom_range(0, 1));
            addr = $urandom;
            din = $urandom;
            @(negedge clk);
        end
        ren = 1'b0;
        wen = 1'b0;
        check({tag, "_busy_cycles"}, lows, exp_lat);
        check({tag, "_mem_reads"}, n_rd - rd0, hit ? 0 : 32);
        check({tag, "_mem_writes"}, n_wr - wr0, vdirty ? 32 : 0);
        if (!hit) check({tag, "_fill_addr"}, rd_first, {t, s, 7'd0});
        if (vdirty) check({tag, "_wb_addr"}, wr_first, {vtag, s, 7'd0});
        check({tag, "_dout"}, dout, exp_dout);
    endtask

    localparam logic [4:0] LB = 5'b00001, LH = 5'b00010, LW = 5'b00100, LBU = 5'b01000, LHU = 5'b10000;
    localparam logic [2:0] SB = 3'b001, SH = 3'b010, SW = 3'b100;

    logic [4:0]  lc_tab [6];
    logic [2:0]  sc_tab [3];
    logic [20:0] tag_tab [4];
    logic [31:0] ra;
    int          rd0, wr0;

    initial begin
        lc_tab  = '{5'd0, LB, LH, LW, LBU, LHU};
        sc_tab  = '{SB, SH, SW};
        tag_tab = '{21'h000000, 21'h000001, 21'h15B3C, 21'h1FFFFF};
        model_reset();

        repeat (3) @(negedge clk);
        check("reset_rdy", {31'd0, cache_rdy}, 32'd0);
        check("reset_dout", dout, 32'd0);
        check("reset_mem_ren", {31'd0, mem_ren}, 32'd0);
        check("reset_mem_wen", {31'd0, mem_wen}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_reset", {31'd0, cache_rdy}, 32'd1);

        do_op(1'b0, 32'h0000_0000, 32'd0, LW, 3'd0, "lw0_miss");
        check("lw0_last_read", rd_last, 32'h0000_007C);
        check("lw0_value", dout, init_word(30'd0));
        do_op(1'b0, 32'h0000_0004, 32'd0, LW, 3'd0, "lw4_hit");
        do_op(1'b0, 32'h0000_0008, 32'd0, LW, 3'd0, "lw8_hit");

        do_op(1'b1, 32'hACE1_2000, 32'hDEAD_BEEF, 5'd0, SW, "sw_ace1");
        do_op(1'b0, 32'hACE1_2000, 32'd0, LW, 3'd0, "lw_ace1");
        check("lw_ace1_const", dout, 32'hDEAD_BEEF);
        do_op(1'b0, 32'hACE1_2004, 32'd0, LW, 3'd0, "lw_ace1_4");

        do_op(1'b0, 32'hBEEF_2000, 32'd0, LW, 3'd0, "lw_beef");
        do_op(1'b0, 32'h1234_2000, 32'd0, LW, 3'd0, "lw_1234_evict");
        check("evict_wb_first", wr_first, 32'hACE1_2000);
        check("evict_mem_value", bmem_rd(30'(32'hACE1_2000 >> 2)), 32'hDEAD_BEEF);

        do_op(1'b1, 32'h0000_0043, 32'h1234_5680, 5'd0, SB, "sb_43");
        do_op(1'b0, 32'h0000_0043, 32'd0, LB, 3'd0, "lb_43");
        check("lb_43_const", dout, 32'hFFFF_FF80);
        do_op(1'b0, 32'h0000_0043, 32'd0, LBU, 3'd0, "lbu_43");
        check("lbu_43_const", dout, 32'h0000_0080);
        do_op(1'b1, 32'h0000_0042, 32'hABCD_8001, 5'd0, SH, "sh_42");
        do_op(1'b0, 32'h0000_0042, 32'd0, LH, 3'd0, "lh_42");
        check("lh_42_const", dout, 32'hFFFF_8001);

        // Reset in the middle of a line fill, then the same load must miss again.
        rd0 = n_rd;
        wr0 = n_wr;
        addr = 32'h5555_5F00; loadcntrl = LW; ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
        repeat (12) @(negedge clk);
        check("midfill_reading", {31'd0, mem_ren}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midfill_rst_rdy", {31'd0, cache_rdy}, 32'd0);
        check("midfill_rst_mem_ren", {31'd0, mem_ren}, 32'd0);
        check("midfill_rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        check("midfill_rst_dout", dout, 32'd0);
        check("midfill_rst_wen", {28'd0, c_wen[3], c_wen[2], c_wen[1], c_wen[0]}, 32'd0);
        check("midfill_no_writes", n_wr - wr0, 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("midfill_rdy_after", {31'd0, cache_rdy}, 32'd1);
        do_op(1'b0, 32'h5555_5F00, 32'd0, LW, 3'd0, "refill_miss");

        for (int i = 0; i < 80; i++) begin
            ra = {tag_tab[$urandom_range(0, 3)], 4'($urandom_range(0, 3)), 7'($urandom_range(0, 127))};
            if ($urandom_range(0, 2) == 0)
                do_op(1'b1, ra, $urandom, 5'd0, sc_tab[$urandom_range(0, 2)], "rand_st");
            else
                do_op(1'b0, ra, 32'd0, lc_tab[$urandom_range(0, 5)], 3'd0, "rand_ld");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache.md
CACHE -- requirements
Module: cache

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 ren, wen  in  1  CPU read / write request, sampled only while cache_rdy=1.
REQ-004 addr  in  32  CPU byte address; din  in  32  store data (right-aligned).
REQ-005 loadcntrl  in  5  one-hot: b0 LB, b1 LH, b2 LW, b3 LBU, b4 LHU; storecntrl  in  3  one-hot: b0 SB, b1 SH, b2 SW.
REQ-006 dout  out  32  load result; cache_rdy  out  1  idle and ready for a request.
REQ-007 mem_ren, mem_wen  out  1; mem_addr  out  32  byte address, word aligned; mem_din  out  32; mem_dout  in  32  valid the cycle after mem_ren.
REQ-008 cell_k_addr  out  10, cell_k_din  out  8, cell_k_sense_en  out  1, cell_k_wen  out  1, cell_k_dout  in  8 (k=0..3): four 1024x8 synchronous SRAM byte lanes; lane k holds word byte k (bits 8k+7:8k); read data valid the cycle after sense_en.

Function
REQ-009 Organisation: 2-way set associative, 16 sets, 128-byte lines (32 words); addr[6:2] word, addr[10:7] set, addr[31:11] tag (21 b); SRAM address = {way, set, word}.
REQ-010 Tags, valid, dirty and one LRU bit per set are held in flops; write-back, write-allocate.
REQ-011 States: IDLE, LOOKUP, SRAM_TO_BUF, BUF_TO_MEM, MEM_TO_BUF, BUF_TO_SRAM, ACCESS, DONE.
REQ-012 IDLE: cache_rdy=1; on wen or ren latch addr/din/cntrl and go LOOKUP; cache_rdy=0 from the next cycle; wen takes priority when both are asserted.
REQ-013 LOOKUP hit -> ACCESS; miss -> victim = first invalid way (way0 first), else the LRU way; victim dirty -> SRAM_TO_BUF, otherwise MEM_TO_BUF.
REQ-014 SRAM_TO_BUF: read 32 victim words into a 32x32 line buffer; BUF_TO_MEM: 32 writes, mem_wen=1, mem_addr={victim tag, set, word, 2'b00}, one word per cycle.
REQ-015 MEM_TO_BUF: 32 reads at {req tag, set, word, 2'b00}, word 0 first; BUF_TO_SRAM: write 32 words to all four lanes; then set tag, valid=1, dirty=0 and go ACCESS.
REQ-016 ACCESS read: assert sense_en on all lanes; the next cycle (DONE) drives dout.
REQ-017 Load formatting: LW ignores addr[1:0]; LH/LHU select the half by addr[1]; LB/LBU select the byte by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend; loadcntrl=0 behaves as LW.
REQ-018 ACCESS write: SW writes all lanes; SH writes lanes {2,3} or {0,1} by addr[1]; SB writes lane addr[1:0]; din low bits are replicated onto the selected lanes; dirty=1; storecntrl=0 writes nothing.
REQ-019 Every ACCESS makes the accessed way MRU (the LRU bit points to the other way); DONE -> IDLE, raising cache_rdy.
REQ-020 Hit latency: cache_rdy low exactly 3 cycles; dout holds its value until the next load completes.
REQ-021 Clean miss adds 64 cycles; a dirty miss adds a further 64 cycles.
REQ-022 Request inputs are ignored while cache_rdy=0.

Reset
REQ-023 While rst=1: state IDLE, all valid/dirty/LRU cleared, dout=0, cache_rdy=0, mem_ren/mem_wen=0, all cell sense_en/wen=0, addresses and data 0.
REQ-024 cache_rdy=1 on the first cycle after rst deasserts.
REQ-025 rst asserted mid-miss aborts immediately with no further memory or SRAM writes; the partially filled line stays invalid.

Verification
REQ-026 After reset, LW 0x0 -> 32 mem reads 0x0..0x7C, then dout = mem[0x0]; LW 0x4 and 0x8 hit (3-cycle cache_rdy low, no mem_ren) with dout = mem[0x4], mem[0x8].
REQ-027 SW 0xDEADBEEF @0xACE12000, then LW 0xACE12000 -> 0xDEADBEEF; LW 0xACE12004 hits.
REQ-028 Dirty 0xACE12000 line, then loads of 0xBEEF2000 and 0x12342000 (same set 0) -> the second evicts the ACE1 line (LRU): 32 mem writes from 0xACE12000 and mem[0xACE12000] = 0xDEADBEEF.
REQ-029 SB 0x80 @0x...3, then LB -> 0xFFFFFF80, LBU -> 0x00000080; SH 0x8001 @+2, LH -> 0xFFFF8001.
REQ-030 rst pulse during MEM_TO_BUF -> outputs take reset values; the following load of the same address misses again.
